// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: command encodings, FSM states and
// helpers that classify a command by its memory footprint.
package mem_stage_pkg;

  localparam int MEM_CMD_W = 6;

  localparam logic [MEM_CMD_W-1:0] CMD_LB  = 6'd1;
  localparam logic [MEM_CMD_W-1:0] CMD_LH  = 6'd2;
  localparam logic [MEM_CMD_W-1:0] CMD_LW  = 6'd3;
  localparam logic [MEM_CMD_W-1:0] CMD_LBU = 6'd4;
  localparam logic [MEM_CMD_W-1:0] CMD_LHU = 6'd5;
  localparam logic [MEM_CMD_W-1:0] CMD_SB  = 6'd6;
  localparam logic [MEM_CMD_W-1:0] CMD_SH  = 6'd7;
  localparam logic [MEM_CMD_W-1:0] CMD_SW  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Number of bytes moved by a command; 0 marks a non-memory command.
  function automatic logic [2:0] byte_count(input logic [MEM_CMD_W-1:0] cmd);
    case (cmd)
      CMD_LB, CMD_LBU, CMD_SB: byte_count = 3'd1;
      CMD_LH, CMD_LHU, CMD_SH: byte_count = 3'd2;
      CMD_LW, CMD_SW:          byte_count = 3'd4;
      default:                 byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [MEM_CMD_W-1:0] cmd);
    is_load = (cmd == CMD_LB) || (cmd == CMD_LH) || (cmd == CMD_LW) ||
              (cmd == CMD_LBU) || (cmd == CMD_LHU);
  endfunction

  function automatic logic is_store(input logic [MEM_CMD_W-1:0] cmd);
    is_store = (cmd == CMD_SB) || (cmd == CMD_SH) || (cmd == CMD_SW);
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load result formatting: picks the loaded width from the command and
// sign- or zero-extends the assembled byte buffer to register width.
module mem_load_ext
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]          i_buf,
  input  logic [MEM_CMD_W-1:0] i_cmd,
  output logic [DATA_W-1:0]    o_data
);

  always_comb begin
    o_data = DATA_W'(i_buf);
    case (i_cmd)
      CMD_LB:  o_data = {{(DATA_W-8){i_buf[7]}},   i_buf[7:0]};
      CMD_LH:  o_data = {{(DATA_W-16){i_buf[15]}}, i_buf[15:0]};
      CMD_LBU: o_data = {{(DATA_W-8){1'b0}},       i_buf[7:0]};
      CMD_LHU: o_data = {{(DATA_W-16){1'b0}},      i_buf[15:0]};
      default: o_data = DATA_W'(i_buf);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes non-memory instructions straight through and serialises
// loads/stores into byte transactions on the 8-bit memory-controller port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CMD_W  = MEM_CMD_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [CMD_W-1:0]  cmdtype,
  input  logic [4:0]        rsd_addr,
  input  logic [DATA_W-1:0] rsd_data,
  input  logic              write_rsd_or_not,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [4:0]        rsd_addr_out,
  output logic [DATA_W-1:0] rsd_data_out,
  output logic              write_rsd_or_not_out,
  output logic              stall_req,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_wdata,
  input  logic              mc_ack,
  input  logic [7:0]        mc_rdata
);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic [1:0]        r_idx;
  logic [31:0]       r_buf;
  logic [CMD_W-1:0]  r_cmd;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic              r_fresh;   // first cycle after reset: outputs forced to 0

  logic              w_is_mem;
  logic              w_last;
  logic [DATA_W-1:0] w_ext;

  assign w_is_mem = (byte_count(cmdtype) != 3'd0);
  assign w_last   = ({1'b0, r_idx} == (byte_count(r_cmd) - 3'd1));

  mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .i_buf  (r_buf),
    .i_cmd  (r_cmd),
    .o_data (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_is_mem && !r_fresh) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (mc_ack && w_last)     w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    rsd_addr_out         = '0;
    rsd_data_out         = '0;
    write_rsd_or_not_out = 1'b0;
    stall_req            = 1'b0;
    mc_req               = 1'b0;
    mc_we                = 1'b0;
    mc_addr              = '0;
    mc_wdata             = '0;
    if (!rst_in && !r_fresh) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            stall_req = 1'b1;
          end else begin
            rsd_addr_out         = rsd_addr;
            rsd_data_out         = rsd_data;
            write_rsd_or_not_out = write_rsd_or_not;
          end
        end
        ST_ACCESS: begin
          stall_req    = 1'b1;
          rsd_addr_out = r_rd;
          mc_req       = 1'b1;
          mc_we        = is_store(r_cmd);
          mc_addr      = r_addr + ADDR_W'(r_idx);
          mc_wdata     = r_sdata[8*r_idx +: 8];
        end
        ST_DONE: begin
          rsd_addr_out = r_rd;
          if (is_load(r_cmd)) begin
            rsd_data_out         = w_ext;
            write_rsd_or_not_out = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; rdy_in low holds every register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
      r_cmd   <= '0;
      r_rd    <= '0;
      r_addr  <= '0;
      r_sdata <= '0;
      r_fresh <= 1'b1;
    end else if (rdy_in) begin
      r_fresh <= 1'b0;
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem && !r_fresh) begin
            r_cmd   <= cmdtype;
            r_rd    <= rsd_addr;
            r_addr  <= mem_addr;
            r_sdata <= store_data;
            r_idx   <= '0;
            r_buf   <= '0;
          end
        end
        ST_ACCESS: begin
          if (mc_ack) begin
            if (is_load(r_cmd)) r_buf[8*r_idx +: 8] <= mc_rdata;
            if (!w_last) r_idx <= r_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
